// File: rtl/fct_credit_scheduler.sv
// Receive-side SpaceWire flow-control scheduler: tracks RX FIFO occupancy and
// outstanding credit, requests FCTs from the TX encoder and flags credit errors.
module fct_credit_scheduler #(
  parameter int AWIDTH     = 6,
  parameter int FIFO_CAP   = 63,
  parameter int MAX_CREDIT = 56,
  parameter int FCT_SIZE   = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              link_run,
  input  logic              rx_char_valid,
  input  logic              rx_rd_pulse,
  input  logic              fct_ack,
  output logic              fct_req,
  output logic              fct_sent,
  output logic [5:0]        credit_out,
  output logic [AWIDTH:0]   occupancy,
  output logic              credit_error
);

  localparam int SW = AWIDTH + 3;

  typedef enum logic [1:0] {IDLE, REQ, GAP} state_e;

  state_e          state_q, state_d;
  logic [5:0]      credit_q, credit_d;
  logic [AWIDTH:0] occ_q, occ_d;
  logic            sent_q, err_q, err_d;
  logic            ackAccepted, canGrant;
  logic [SW-1:0]   creditSum, headroom;

  // A grant is only safe if the far end stays within the credit ceiling and
  // every N-Char it may then send still fits in the FIFO.
  assign ackAccepted = (state_q == REQ) && fct_ack && link_run;
  assign creditSum   = SW'(credit_q) + SW'(FCT_SIZE);
  assign headroom    = SW'(occ_q) + SW'(credit_q) + SW'(FCT_SIZE);
  assign canGrant    = link_run && (creditSum <= SW'(MAX_CREDIT))
                       && (headroom <= SW'(FIFO_CAP));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      credit_q <= '0;
      occ_q    <= '0;
      sent_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      credit_q <= credit_d;
      occ_q    <= occ_d;
      sent_q   <= ackAccepted;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (canGrant) state_d = REQ;
      REQ:     if (fct_ack) state_d = GAP;
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (!link_run) state_d = IDLE;
  end

  // Link loss flushes the FIFO and forfeits all outstanding credit.
  always_comb begin
    credit_d = credit_q;
    occ_d    = occ_q;
    err_d    = rx_char_valid && (credit_q == 6'd0) && !ackAccepted;
    if (!link_run) begin
      credit_d = '0;
      occ_d    = '0;
    end else begin
      case ({ackAccepted, rx_char_valid})
        2'b11:   credit_d = credit_q + 6'(FCT_SIZE - 1);
        2'b10:   credit_d = credit_q + 6'(FCT_SIZE);
        2'b01:   credit_d = (credit_q == 6'd0) ? 6'd0 : credit_q - 6'd1;
        default: credit_d = credit_q;
      endcase
      if (rx_char_valid && !rx_rd_pulse && (occ_q != (AWIDTH+1)'(FIFO_CAP)))
        occ_d = occ_q + 1'b1;
      else if (rx_rd_pulse && !rx_char_valid && (occ_q != '0))
        occ_d = occ_q - 1'b1;
    end
  end

  assign fct_req      = (state_q == REQ);
  assign fct_sent     = sent_q;
  assign credit_out   = credit_q;
  assign occupancy    = occ_q;
  assign credit_error = err_q;

endmodule

// File: tb/tb_fct_credit_scheduler.sv
// Self-checking bench for fct_credit_scheduler: directed scenarios plus random
// traffic compared every cycle against a behavioural credit/occupancy model.
module tb_fct_credit_scheduler;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       link_run = 1'b0;
  logic       rx_char_valid = 1'b0;
  logic       rx_rd_pulse = 1'b0;
  logic       fct_ack = 1'b0;
  logic       fct_req;
  logic       fct_sent;
  logic [5:0] credit_out;
  logic [6:0] occupancy;
  logic       credit_error;

  int errors = 0;
  int checks = 0;
  int sentSeen = 0;

  int mCredit, mOcc;
  bit mReq, mGap, mSent, mErr;
  bit acc, eligible;
  int nCredit, nOcc;

  fct_credit_scheduler dut (
    .clock(clock), .reset(reset), .link_run(link_run),
    .rx_char_valid(rx_char_valid), .rx_rd_pulse(rx_rd_pulse), .fct_ack(fct_ack),
    .fct_req(fct_req), .fct_sent(fct_sent), .credit_out(credit_out),
    .occupancy(occupancy), .credit_error(credit_error)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input bit lr, input bit rx, input bit rd, input bit ack);
    link_run = lr;
    rx_char_valid = rx;
    rx_rd_pulse = rd;
    fct_ack = ack;
    @(negedge clock);
  endtask

  task automatic waitReq(input string name);
    int n = 0;
    while (!fct_req && n < 20) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
      n++;
    end
    if (!fct_req) checkOutput(name, fct_req, 1);
  endtask

  // Reference: credit is granted FCT_SIZE at a time while both the credit
  // ceiling and FIFO space allow it; a request lives until acked, then one
  // quiet cycle must pass before eligibility is evaluated again.
  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      mCredit <= 0; mOcc <= 0; mReq <= 0; mGap <= 0; mSent <= 0; mErr <= 0;
    end else begin
      acc = mReq && fct_ack && link_run;
      eligible = (mCredit + 8 <= 56) && (mOcc + mCredit + 8 <= 63);
      nCredit = mCredit + (acc ? 8 : 0) - (rx_char_valid ? 1 : 0);
      if (nCredit < 0) nCredit = 0;
      nOcc = mOcc + int'(rx_char_valid) - int'(rx_rd_pulse);
      if (nOcc < 0) nOcc = 0;
      if (nOcc > 63) nOcc = 63;
      mErr <= rx_char_valid && (mCredit == 0) && !acc;
      if (!link_run) begin
        mCredit <= 0; mOcc <= 0; mReq <= 0; mGap <= 0; mSent <= 0;
      end else begin
        mCredit <= nCredit;
        mOcc <= nOcc;
        mSent <= acc;
        mGap <= acc;
        mReq <= mReq ? !fct_ack : (!mGap && eligible);
      end
    end
  end

  always @(negedge clock) begin
    if (fct_sent) sentSeen++;
    if (reset) begin
      checkOutput("req", fct_req, int'(mReq));
      checkOutput("sent", fct_sent, int'(mSent));
      checkOutput("credit", credit_out, mCredit);
      checkOutput("occ", occupancy, mOcc);
      checkOutput("cerr", credit_error, int'(mErr));
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int hi = 0;
    bit ackNow;
    int sentBefore;

    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    checkOutput("rst_req", fct_req, 0);
    checkOutput("rst_credit", credit_out, 0);
    checkOutput("rst_occ", occupancy, 0);

    // Bring-up: ack each request on its second visible cycle.
    repeat (200) begin
      ackNow = 0;
      if (fct_req) begin
        hi++;
        if (hi >= 2) begin ackNow = 1; hi = 0; end
      end else hi = 0;
      applyStimulus(1'b1, 1'b0, 1'b0, ackNow);
    end
    checkOutput("s1_credit", credit_out, 56);
    checkOutput("s1_model_credit", mCredit, 56);
    checkOutput("s1_fcts", sentSeen, 7);
    checkOutput("s1_req", fct_req, 0);

    repeat (8) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("s2_credit", credit_out, 48);
    checkOutput("s2_occ", occupancy, 8);
    checkOutput("s2_model_occ", mOcc, 8);
    repeat (4) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("s2_noreq", fct_req, 0);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
    checkOutput("s2_occ_rd", occupancy, 7);
    repeat (2) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("s2_req", fct_req, 1);

    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("s3_credit0", credit_out, 0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("s3_cerr", credit_error, 1);
    checkOutput("s3_credit", credit_out, 0);
    checkOutput("s3_occ", occupancy, 1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("s3_cerr_pulse", credit_error, 0);

    waitReq("s4_wait1");
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
    checkOutput("s4_credit8", credit_out, 8);
    repeat (3) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("s4_credit5", credit_out, 5);
    waitReq("s4_wait2");
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
    checkOutput("s4_credit12", credit_out, 12);
    checkOutput("s4_sent", fct_sent, 1);
    checkOutput("s4_cerr", credit_error, 0);

    waitReq("s5_wait");
    sentBefore = sentSeen;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("s5_req", fct_req, 0);
    checkOutput("s5_credit", credit_out, 0);
    checkOutput("s5_occ", occupancy, 0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("s5_nosent", sentSeen - sentBefore, 0);
    checkOutput("s5_credit_after", credit_out, 0);

    repeat (70) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("s6_occ_max", occupancy, 63);
    repeat (70) applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
    checkOutput("s6_occ_min", occupancy, 0);
    repeat (3) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    waitReq("s6_wait");
    #2 reset = 1'b0;
    #1;
    checkOutput("s6_areset_req", fct_req, 0);
    checkOutput("s6_areset_credit", credit_out, 0);
    checkOutput("s6_areset_occ", occupancy, 0);
    checkOutput("s6_areset_cerr", credit_error, 0);
    checkOutput("s6_areset_sent", fct_sent, 0);
    @(negedge clock);
    reset = 1'b1;

    repeat (3000) begin
      applyStimulus($urandom_range(0, 49) != 0, $urandom_range(0, 9) < 4,
                    $urandom_range(0, 9) < 4, $urandom_range(0, 1) == 1);
    end
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
